// File: rtl/host_loader_if.sv
// host_loader_if: groups the program ROM port, byte-level UART rx/tx ports,
// stdin/stdout byte streams and the status flags of host_loader.
// Signal prefixes (i_/o_) are written from the loader's point of view.
// modport slave  : used by host_loader itself
// modport master : used by whatever drives the loader (system or bench)
interface host_loader_if;
  logic        i_start;
  logic [31:0] i_prog_size_byte;
  logic [29:0] o_prog_read_addr;
  logic [31:0] i_prog_read_data;
  logic [7:0]  i_rx_data;
  logic        i_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_busy;
  logic        i_stdin_valid;
  logic [7:0]  i_stdin_data;
  logic        o_stdin_ready;
  logic        o_stdout_valid;
  logic [7:0]  o_stdout_data;
  logic        o_loaded;
  logic        o_error;

  modport slave (
    input  i_start, i_prog_size_byte, i_prog_read_data, i_rx_data, i_rx_ready,
           i_tx_busy, i_stdin_valid, i_stdin_data,
    output o_prog_read_addr, o_tx_data, o_tx_start, o_stdin_ready,
           o_stdout_valid, o_stdout_data, o_loaded, o_error
  );

  modport master (
    output i_start, i_prog_size_byte, i_prog_read_data, i_rx_data, i_rx_ready,
           i_tx_busy, i_stdin_valid, i_stdin_data,
    input  o_prog_read_addr, o_tx_data, o_tx_start, o_stdin_ready,
           o_stdout_valid, o_stdout_data, o_loaded, o_error
  );
endinterface

// File: rtl/host_loader.sv
// host_loader: waits for the host's 0x99 sync byte, sends the program size
// (4 bytes, little-endian) and the program image read from ROM over the UART,
// waits for the host's 0xAA acknowledge, then bridges stdin -> UART tx and
// UART rx -> stdout.
// Optional build macro: HOST_LOADER_TIMEOUT_EN adds a wait-state timeout that
// moves the FSM to ERROR after TIMEOUT_CYCLES cycles without the awaited byte.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for a start pulse
// S_WAIT_99   | waiting for host sync byte 0x99
// S_SEND_SIZE | sending the 4 program size bytes
// S_SEND_PROG | sending program bytes from ROM
// S_WAIT_AA   | waiting for host acknowledge byte 0xAA
// S_STREAM    | program loaded, stdin/stdout bridged over the UART
// S_ERROR     | timeout while waiting (only with HOST_LOADER_TIMEOUT_EN)
module host_loader #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input logic         i_clk,
  input logic         i_reset,
  host_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_99,
    S_SEND_SIZE,
    S_SEND_PROG,
    S_WAIT_AA,
    S_STREAM,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_size;
  logic [31:0] r_cnt;
  logic [1:0]  r_sidx;
  logic [29:0] r_addr;
  logic [7:0]  r_tx_data;
  logic        r_pend;
  logic        r_tx_start_q;
  logic        r_stdout_valid;
  logic [7:0]  r_stdout_data;

  logic        w_tx_start;
  logic        w_can_load;
  logic        w_load;
  logic [31:0] w_shift;
  logic        w_stdin_ready;
  logic        w_accept;
  logic        w_tmo_hit;

  // A byte may be staged into tx_data only once the transmitter is idle, so
  // tx_data never changes while the previous byte is still being sent. The
  // mandatory idle cycle after each tx_start also gives the ROM its one cycle
  // of read latency after prog_read_addr advances.
  assign w_can_load = ~r_pend & ~bus.i_tx_busy & ~r_tx_start_q;
  assign w_accept   = (r_state == S_STREAM) & bus.i_stdin_valid & w_stdin_ready;

`ifdef HOST_LOADER_TIMEOUT_EN
  logic [23:0] r_tmo;

  assign w_tmo_hit = (r_tmo == TIMEOUT_CYCLES - 24'd1);

  // Wait-state timer: cleared on every state change, counts while waiting.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tmo <= 24'd0;
    end else if (r_state != w_state_nxt) begin
      r_tmo <= 24'd0;
    end else if (r_state == S_WAIT_99 || r_state == S_WAIT_AA) begin
      r_tmo <= r_tmo + 24'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo_hit        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state, tx launch and byte selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift       = 32'h0;
    w_load        = 1'b0;
    w_stdin_ready = 1'b0;
    w_tx_start    = r_pend & ~bus.i_tx_busy & ~r_tx_start_q & ~i_reset;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_WAIT_99;
      end
      S_WAIT_99: begin
        if (bus.i_rx_ready && bus.i_rx_data == 8'h99) w_state_nxt = S_SEND_SIZE;
        else if (w_tmo_hit)                           w_state_nxt = S_ERROR;
      end
      S_SEND_SIZE: begin
        w_load  = w_can_load;
        w_shift = r_size >> {r_sidx, 3'b000};
        if (w_tx_start && r_sidx == 2'd3)
          w_state_nxt = (r_size == 32'd0) ? S_WAIT_AA : S_SEND_PROG;
      end
      S_SEND_PROG: begin
        w_load  = w_can_load;
        w_shift = bus.i_prog_read_data >> {r_cnt[1:0], 3'b000};
        if (w_tx_start && r_cnt == r_size - 32'd1) w_state_nxt = S_WAIT_AA;
      end
      S_WAIT_AA: begin
        if (bus.i_rx_ready && bus.i_rx_data == 8'hAA) w_state_nxt = S_STREAM;
        else if (w_tmo_hit)                           w_state_nxt = S_ERROR;
      end
      S_STREAM: begin
        w_stdin_ready = ~bus.i_tx_busy & ~w_tx_start;
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Session datapath: size latch, byte counters, ROM address, tx and stdout regs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_size         <= 32'd0;
      r_cnt          <= 32'd0;
      r_sidx         <= 2'd0;
      r_addr         <= 30'd0;
      r_tx_data      <= 8'd0;
      r_pend         <= 1'b0;
      r_tx_start_q   <= 1'b0;
      r_stdout_valid <= 1'b0;
      r_stdout_data  <= 8'd0;
    end else begin
      r_tx_start_q <= w_tx_start;
      if (w_tx_start) r_pend <= 1'b0;
      if (w_load) begin
        r_tx_data <= w_shift[7:0];
        r_pend    <= 1'b1;
      end
      if (w_accept) begin
        r_tx_data <= bus.i_stdin_data;
        r_pend    <= 1'b1;
      end
      if (r_state == S_IDLE && bus.i_start) begin
        r_size <= bus.i_prog_size_byte;
        r_cnt  <= 32'd0;
        r_sidx <= 2'd0;
        r_addr <= 30'd0;
        r_pend <= 1'b0;
      end
      if (r_state == S_SEND_SIZE && w_tx_start) r_sidx <= r_sidx + 2'd1;
      if (r_state == S_SEND_PROG && w_tx_start) begin
        r_cnt <= r_cnt + 32'd1;
        if (r_cnt[1:0] == 2'd3) r_addr <= r_addr + 30'd1;
      end
      r_stdout_valid <= (r_state == S_STREAM) & bus.i_rx_ready;
      if (r_state == S_STREAM && bus.i_rx_ready) r_stdout_data <= bus.i_rx_data;
    end
  end

  assign bus.o_prog_read_addr = r_addr;
  assign bus.o_tx_data        = r_tx_data;
  assign bus.o_tx_start       = w_tx_start;
  assign bus.o_stdin_ready    = w_stdin_ready;
  assign bus.o_stdout_valid   = r_stdout_valid;
  assign bus.o_stdout_data    = r_stdout_data;
  assign bus.o_loaded         = (r_state == S_STREAM);
`ifdef HOST_LOADER_TIMEOUT_EN
  assign bus.o_error          = (r_state == S_ERROR);
`else
  assign bus.o_error          = 1'b0;
`endif

endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd10_000_000, cycles allowed in a wait state before timeout (used only when HOST_LOADER_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a load session from IDLE.
REQ-005 prog_size_byte  input  32  program length in bytes; sampled on start.
REQ-006 prog_read_addr  output  30  word address into program ROM.
REQ-007 prog_read_data  input  32  ROM word; valid 1 cycle after prog_read_addr changes.
REQ-008 rx_data  input  8  byte from byte-level UART receiver.
REQ-009 rx_ready  input  1  one-cycle pulse; rx_data valid.
REQ-010 tx_data  output  8  byte to byte-level UART transmitter.
REQ-011 tx_start  output  1  one-cycle pulse; transmitter latches tx_data.
REQ-012 tx_busy  input  1  transmitter busy; rises the cycle after tx_start.
REQ-013 stdin_valid / stdin_data  input  1 / 8  host byte to forward to the CPU.
REQ-014 stdin_ready  output  1  stdin byte accepted when valid and ready both high.
REQ-015 stdout_valid / stdout_data  output  1 / 8  one-cycle pulse carrying a byte from the CPU.
REQ-016 loaded  output  1  high while in STREAM.
REQ-017 error  output  1  high while in ERROR.

Function
REQ-018 States: IDLE, WAIT_99, SEND_SIZE, SEND_PROG, WAIT_AA, STREAM, ERROR.
REQ-019 IDLE -> WAIT_99 on start; latch prog_size_byte; clear byte counter and prog_read_addr.
REQ-020 WAIT_99: an rx byte 0x99 -> SEND_SIZE; any other rx byte is discarded.
REQ-021 SEND_SIZE: transmit the 4 size bytes little-endian (bits 7:0 first); after the 4th tx_start -> SEND_PROG, or -> WAIT_AA if size is 0.
REQ-022 SEND_PROG: transmit each ROM word little-endian; increment prog_read_addr after the 4th byte of a word; stop after exactly prog_size_byte bytes (trailing partial word truncated) -> WAIT_AA.
REQ-023 tx_start asserts only in a cycle with tx_busy=0 and tx_start=0 in the previous cycle; tx_data is stable from the tx_start cycle on.
REQ-024 ROM data is used no earlier than 1 cycle after prog_read_addr changes.
REQ-025 WAIT_AA: rx byte 0xAA -> STREAM; other rx bytes discarded; rx bytes in SEND_SIZE/SEND_PROG discarded.
REQ-026 STREAM: stdin_ready = ~tx_busy & ~tx_start; an accepted stdin byte drives tx_data with a tx_start pulse on the next cycle.
REQ-027 STREAM: each rx_ready produces stdout_valid=1, stdout_data=rx_data exactly 1 cycle later; no drop, no backpressure.
REQ-028 STREAM and ERROR are left only by reset; start is ignored outside IDLE.
REQ-029 Byte counter is 32-bit; sizes up to 2^32-1 are handled without wrap.

Reset
REQ-030 On reset, state=IDLE and tx_start=0, tx_data=0, stdin_ready=0, stdout_valid=0, stdout_data=0, prog_read_addr=0, loaded=0, error=0.
REQ-031 Reset mid-session aborts immediately; no further tx_start is issued until the next start.

Configuration
REQ-032 Macro HOST_LOADER_TIMEOUT_EN defined: a counter clears on entry to WAIT_99/WAIT_AA; reaching TIMEOUT_CYCLES without the expected byte -> ERROR.
REQ-033 Macro HOST_LOADER_TIMEOUT_EN undefined: no counter is built, ERROR is unreachable, and error is tied to 0.

Verification
REQ-034 start, size=8, ROM={0x03020100,0x07060504}, rx 0x99 -> tx sequence 08 00 00 00 00 01 02 03 04 05 06 07.
REQ-035 size=6 -> tx: size bytes, then 00 01 02 03 04 05; no 7th program byte; then WAIT_AA.
REQ-036 size=0, rx 0x99 -> 4 zero bytes, then WAIT_AA; rx 0x55 ignored; rx 0xAA -> loaded=1.
REQ-037 STREAM: stdin 0x41 with tx_busy held high for 10 cycles -> stdin_ready=0 during busy; single tx_start with tx_data=0x41 afterwards; rx 0x42 -> stdout_valid pulse with 0x42 one cycle later.
REQ-038 Reset asserted mid-SEND_PROG -> next cycle all outputs at reset values, no tx_start; a new start restarts from WAIT_99.
REQ-039 With HOST_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100, no 0x99 received -> error=1 at cycle 100 after start; without the macro, error stays 0.
